// File: rtl/register_64bit_unpack_pkg.sv
// Shared types for the 64-to-32 bit unpacker.
// Holds the FSM state encoding and the data widths.
package register_64bit_unpack_pkg;

    localparam int WORD_W = 64;
    localparam int HALF_W = 32;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FIRST  = 2'b01,
        SECOND = 2'b10
    } state_t;

endpackage

// File: rtl/register_32bit.sv
// 32-bit holding register with a synchronous, active-high reset and a write enable.
// Reset takes priority over the write.
module register_32bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] data_q;
    logic [31:0] data_d;

    always_comb begin
        data_d = data_q;
        if (write) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/register_64bit_unpack.sv
// Splits each accepted 64-bit word into two 32-bit beats on a valid/ready stream.
// LOW_FIRST selects whether bits [31:0] or bits [63:32] go out first.
module register_64bit_unpack
    import register_64bit_unpack_pkg::*;
#(
    parameter int LOW_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [HALF_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic [CNT_W-1:0]    word_count
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   word_count_q;
    logic [CNT_W-1:0]   word_count_d;
    logic [HALF_W-1:0]  lo_q;
    logic [HALF_W-1:0]  hi_q;
    logic [HALF_W-1:0]  first_half;
    logic [HALF_W-1:0]  second_half;
    logic               in_xfer;
    logic               out_xfer;

    register_32bit u_reg_lo (
        .clk   (clk),
        .rst   (rst),
        .write (in_xfer),
        .d     (in_data[HALF_W-1:0]),
        .q     (lo_q)
    );

    register_32bit u_reg_hi (
        .clk   (clk),
        .rst   (rst),
        .write (in_xfer),
        .d     (in_data[WORD_W-1:HALF_W]),
        .q     (hi_q)
    );

    assign first_half  = (LOW_FIRST != 0) ? lo_q : hi_q;
    assign second_half = (LOW_FIRST != 0) ? hi_q : lo_q;

    // Outputs are forced to their idle values while rst is high, not just after the edge.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        if (!rst) begin
            case (state_q)
                FIRST: begin
                    in_ready  = 1'b0;
                    out_valid = 1'b1;
                    out_data  = first_half;
                end
                SECOND: begin
                    in_ready  = out_ready;
                    out_valid = 1'b1;
                    out_last  = 1'b1;
                    out_data  = second_half;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;
    assign word_count = rst ? '0 : word_count_q;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (out_xfer) begin
                    state_d = SECOND;
                end
            end
            SECOND: begin
                if (out_xfer) begin
                    word_count_d = word_count_q + 1'b1;
                    state_d      = in_xfer ? FIRST : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_register_64bit_unpack.sv
// Bench for register_64bit_unpack: both LOW_FIRST variants run side by side
// against a queue-of-halves model, plus directed literal checks.
module tb_register_64bit_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready1, out_valid1, out_last1;
    logic [31:0] out_data1;
    logic [7:0]  word_count1;
    logic        in_ready0, out_valid0, out_last0;
    logic [31:0] out_data0;
    logic [7:0]  word_count0;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    register_64bit_unpack #(.LOW_FIRST(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .out_data   (out_data1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_last   (out_last1),
        .word_count (word_count1)
    );

    register_64bit_unpack #(.LOW_FIRST(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .out_data   (out_data0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_last   (out_last0),
        .word_count (word_count0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: pending halves in emission order, bit 32 marks the second half.
    logic [32:0] mq1[$];
    logic [32:0] mq0[$];
    logic [7:0]  mcnt = 8'd0;
    bit          m_ir, m_ox;

    always @(posedge clk) begin
        if (rst) begin
            mq1.delete();
            mq0.delete();
            mcnt = 8'd0;
        end else begin
            m_ir = (mq1.size() == 0) || (mq1.size() == 1 && out_ready);
            m_ox = (mq1.size() != 0) && out_ready;
            if (m_ox) begin
                if (mq1[0][32]) mcnt = mcnt + 8'd1;
                void'(mq1.pop_front());
                void'(mq0.pop_front());
            end
            if (in_valid && m_ir) begin
                mq1.push_back({1'b0, in_data[31:0]});
                mq1.push_back({1'b1, in_data[63:32]});
                mq0.push_back({1'b0, in_data[63:32]});
                mq0.push_back({1'b1, in_data[31:0]});
            end
        end
    end

    logic        e_ir, e_ov, e_ol0, e_ol1;
    logic [31:0] e_od1, e_od0;
    logic [7:0]  e_wc;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                e_ir = 1'b1; e_ov = 1'b0; e_ol1 = 1'b0; e_ol0 = 1'b0;
                e_od1 = '0; e_od0 = '0; e_wc = '0;
            end else begin
                e_ov  = (mq1.size() != 0);
                e_ir  = (mq1.size() == 0) || (mq1.size() == 1 && out_ready);
                e_od1 = e_ov ? mq1[0][31:0] : 32'd0;
                e_od0 = e_ov ? mq0[0][31:0] : 32'd0;
                e_ol1 = e_ov ? mq1[0][32] : 1'b0;
                e_ol0 = e_ov ? mq0[0][32] : 1'b0;
                e_wc  = mcnt;
            end
            chk("m_in_ready1",   64'(in_ready1),   64'(e_ir));
            chk("m_out_valid1",  64'(out_valid1),  64'(e_ov));
            chk("m_out_last1",   64'(out_last1),   64'(e_ol1));
            chk("m_out_data1",   64'(out_data1),   64'(e_od1));
            chk("m_word_count1", 64'(word_count1), 64'(e_wc));
            chk("m_in_ready0",   64'(in_ready0),   64'(e_ir));
            chk("m_out_valid0",  64'(out_valid0),  64'(e_ov));
            chk("m_out_last0",   64'(out_last0),   64'(e_ol0));
            chk("m_out_data0",   64'(out_data0),   64'(e_od0));
            chk("m_word_count0", 64'(word_count0), 64'(e_wc));
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [63:0] w[4];
    int k, nb, first_c, last_c;
    bit acc;
    logic [31:0] held;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready1),   64'd1);
        chk("rst_out_valid", 64'(out_valid1),  64'd0);
        chk("rst_out_data",  64'(out_data1),   64'd0);
        chk("rst_count",     64'(word_count1), 64'd0);

        // Single word, both orderings
        step();
        in_data  = 64'h1122334455667788;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = 64'hDEADBEEFCAFEF00D;
        @(negedge clk);
        chk("single_first1", 64'(out_data1), 64'h55667788);
        chk("single_last1a", 64'(out_last1), 64'd0);
        chk("single_first0", 64'(out_data0), 64'h11223344);
        step();
        @(negedge clk);
        chk("single_second1", 64'(out_data1), 64'h11223344);
        chk("single_last1b",  64'(out_last1), 64'd1);
        chk("single_second0", 64'(out_data0), 64'h55667788);
        step();
        @(negedge clk);
        chk("single_idle",  64'(out_valid1),  64'd0);
        chk("single_count", 64'(word_count1), 64'd1);

        // Back-pressure in FIRST with in_data churning
        do_reset();
        in_data   = 64'hA5A500005A5AFFFF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = {$urandom, $urandom};
            @(negedge clk);
            chk("bp_data_stable", 64'(out_data1), 64'h5A5AFFFF);
            chk("bp_in_ready",    64'(in_ready1), 64'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_first", 64'(out_data1), 64'h5A5AFFFF);
        step();
        @(negedge clk);
        chk("bp_rel_second", 64'(out_data1), 64'hA5A50000);
        chk("bp_rel_last",   64'(out_last1), 64'd1);
        step();

        // Back-to-back words
        do_reset();
        w[0] = 64'h0000000100000002;
        w[1] = 64'h0000000300000004;
        w[2] = 64'hFFFFFFFF00000000;
        w[3] = 64'h123456789ABCDEF0;
        k = 0; nb = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (k < 4);
            in_data  = w[(k < 4) ? k : 0];
            @(negedge clk);
            if (out_valid1) begin
                nb++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            acc = in_valid && in_ready1;
            step();
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("b2b_accepted", 64'(k),                    64'd4);
        chk("b2b_beats",    64'(nb),                   64'd8);
        chk("b2b_no_gap",   64'(last_c - first_c + 1), 64'd8);
        @(negedge clk);
        chk("b2b_count",    64'(word_count1),          64'd4);

        // Reset while in SECOND
        do_reset();
        in_data  = 64'h0BADF00D12345678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("rs_in_second", 64'(out_last1), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_out_valid", 64'(out_valid1),  64'd0);
        chk("rs_in_ready",  64'(in_ready1),   64'd1);
        chk("rs_count",     64'(word_count1), 64'd0);
        step();

        // 256 words wrap the counter
        do_reset();
        k = 0;
        held = 32'h0;
        for (int c = 0; c < 700 && k < 256; c++) begin
            in_valid = 1'b1;
            held     = held + 32'h01010101;
            in_data  = {held, ~held};
            @(negedge clk);
            acc = in_ready1;
            if (k == 255 && acc) chk("wrap_at_255", 64'(word_count1), 64'd254);
            step();
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("wrap_accepted", 64'(k), 64'd256);
        step();
        step();
        @(negedge clk);
        chk("wrap_count", 64'(word_count1), 64'd0);
        chk("wrap_idle",  64'(out_valid1),  64'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
